// File: rtl/spatial_encoder_multimod.sv
// Spatial encoder: binds each channel's item-memory row with a sign-selected projection row,
// majority-bundles per modality, then takes a per-bit majority across modalities.
module spatial_encoder_multimod #(
    parameter int unsigned HV_DIMENSION   = 2000,
    parameter int unsigned CHANNEL_WIDTH  = 4,
    parameter int unsigned NUM_MODALITIES = 3,
    parameter logic [31:0] MOD_CHANNELS   = {8'd32, 8'd77, 8'd105, 8'd0},
    parameter int unsigned TOTAL_CHANNELS = 214,
    parameter int unsigned ADDR_W         = 8
) (
    input  logic                                      Clk_CI,
    input  logic                                      Reset_RI,
    input  logic                                      ValidIn_SI,
    output logic                                      ReadyOut_SO,
    input  logic [TOTAL_CHANNELS*CHANNEL_WIDTH-1:0]   ChannelsInput_DI,
    output logic                                      ValidOut_SO,
    input  logic                                      ReadyIn_SI,
    output logic [HV_DIMENSION-1:0]                   HypervectorOut_DO,
    output logic                                      MemReqValid_SO,
    input  logic                                      MemReqReady_SI,
    output logic [ADDR_W-1:0]                         MemAddr_DO,
    input  logic                                      MemRespValid_SI,
    input  logic [HV_DIMENSION-1:0]                   MemIM_DI,
    input  logic [HV_DIMENSION-1:0]                   MemProjPos_DI,
    input  logic [HV_DIMENSION-1:0]                   MemProjNeg_DI,
    output logic                                      Busy_SO
);

    function automatic int unsigned max_channels();
        int unsigned mx = 0;
        for (int i = 0; i < 4; i++) begin
            if (32'(i) < NUM_MODALITIES && 32'(MOD_CHANNELS[31-8*i -: 8]) > mx) begin
                mx = 32'(MOD_CHANNELS[31-8*i -: 8]);
            end
        end
        return mx;
    endfunction

    localparam int unsigned CNT_W = $clog2(max_channels() + 1);

    // Tie between modalities (even count only) falls back to modality 0.
    function automatic logic major_bit(input logic [3:0] bits);
        int unsigned ones = 0;
        for (int i = 0; i < 4; i++) begin
            if (32'(i) < NUM_MODALITIES) ones += 32'(bits[i]);
        end
        if (2 * ones > NUM_MODALITIES) return 1'b1;
        if (2 * ones < NUM_MODALITIES) return 1'b0;
        return bits[0];
    endfunction

    typedef enum logic [2:0] {StIdle, StReq, StWait, StClose, StDone} state_e;

    state_e                    r_state, w_state_next;
    logic [TOTAL_CHANNELS-1:0] r_signs, w_in_signs;
    logic [ADDR_W-1:0]         r_c;
    logic [7:0]                r_l, w_n;
    logic [1:0]                r_m;
    logic [CNT_W-1:0]          r_cnt [HV_DIMENSION];
    logic [HV_DIMENSION-1:0]   r_t0, r_t1, w_hv, w_mod_new, w_major;
    logic [HV_DIMENSION-1:0]   r_mod [4];
    logic                      w_last_ch, w_last_mod, w_unused_features;

    // Only the sign of each feature selects the projection, so only the sign is kept.
    for (genvar g = 0; g < TOTAL_CHANNELS; g++) begin : g_sign
        assign w_in_signs[g] = ChannelsInput_DI[(TOTAL_CHANNELS-g)*CHANNEL_WIDTH-1];
    end
    assign w_unused_features = ^ChannelsInput_DI;

    assign w_hv       = MemIM_DI ^ (r_signs[r_c] ? MemProjNeg_DI : MemProjPos_DI);
    assign w_last_ch  = (r_l == w_n - 8'd1);
    assign w_last_mod = (r_m == 2'(NUM_MODALITIES - 1));

    always_comb begin
        w_n = 8'd0;
        case (r_m)
            2'd0:    w_n = MOD_CHANNELS[31:24];
            2'd1:    w_n = MOD_CHANNELS[23:16];
            2'd2:    w_n = MOD_CHANNELS[15:8];
            default: w_n = MOD_CHANNELS[7:0];
        endcase
    end

    always_comb begin
        w_mod_new = '0;
        w_major   = '0;
        for (int k = 0; k < HV_DIMENSION; k++) begin
            if (2 * 32'(r_cnt[k]) > 32'(w_n)) begin
                w_mod_new[k] = 1'b1;
            end else if (2 * 32'(r_cnt[k]) < 32'(w_n)) begin
                w_mod_new[k] = 1'b0;
            end else begin
                w_mod_new[k] = r_t0[k] ^ r_t1[k];
            end
            w_major[k] = major_bit({r_mod[3][k], r_mod[2][k], r_mod[1][k], r_mod[0][k]});
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (ValidIn_SI) w_state_next = StReq;
            StReq:   if (MemReqReady_SI) w_state_next = StWait;
            StWait:  if (MemRespValid_SI) w_state_next = w_last_ch ? StClose : StReq;
            StClose: w_state_next = w_last_mod ? StDone : StReq;
            StDone:  if (ReadyIn_SI) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            r_state <= StIdle;
            r_signs <= '0;
            r_c     <= '0;
            r_l     <= '0;
            r_m     <= '0;
            r_t0    <= '0;
            r_t1    <= '0;
            for (int k = 0; k < HV_DIMENSION; k++) r_cnt[k] <= '0;
            for (int i = 0; i < 4; i++) r_mod[i] <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (ValidIn_SI) begin
                        r_signs <= w_in_signs;
                        r_c     <= '0;
                        r_l     <= '0;
                        r_m     <= '0;
                        for (int k = 0; k < HV_DIMENSION; k++) r_cnt[k] <= '0;
                    end
                end
                StWait: begin
                    if (MemRespValid_SI) begin
                        for (int k = 0; k < HV_DIMENSION; k++) begin
                            r_cnt[k] <= r_cnt[k] + CNT_W'(w_hv[k]);
                        end
                        if (r_l == 8'd0) r_t0 <= w_hv;
                        if (r_l == 8'd1) r_t1 <= w_hv;
                        if (!w_last_ch) begin
                            r_c <= r_c + ADDR_W'(1);
                            r_l <= r_l + 8'd1;
                        end
                    end
                end
                StClose: begin
                    r_mod[r_m] <= w_mod_new;
                    r_l        <= '0;
                    for (int k = 0; k < HV_DIMENSION; k++) r_cnt[k] <= '0;
                    if (!w_last_mod) begin
                        r_m <= r_m + 2'd1;
                        r_c <= r_c + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ReadyOut_SO       = (r_state == StIdle);
    assign Busy_SO           = (r_state != StIdle);
    assign MemReqValid_SO    = (r_state == StReq);
    assign MemAddr_DO        = r_c;
    assign ValidOut_SO       = (r_state == StDone);
    assign HypervectorOut_DO = w_major;

endmodule

// File: tb/tb_spatial_encoder_multimod.sv
// Bench for spatial_encoder_multimod: random samples and memory timing against a per-sample
// reference computed directly from the encoding rules.
module tb_spatial_encoder_multimod;
    localparam int HV = 16;
    localparam int CW = 4;
    localparam int NM = 4;
    localparam int T  = 10;
    localparam int AW = 4;
    localparam logic [31:0] MODC = {8'd2, 8'd3, 8'd4, 8'd1};
    localparam int NCH [NM] = '{2, 3, 4, 1};
    localparam int BASE_LAT = 2 * T + NM + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_in, ready_out, valid_out, ready_in;
    logic [T*CW-1:0]   chans;
    logic [HV-1:0]     hv_out, mem_im, mem_pos, mem_neg;
    logic              req_valid, req_ready, resp_valid, busy;
    logic [AW-1:0]     mem_addr;

    logic [HV-1:0] im [T];
    logic [HV-1:0] pp [T];
    logic [HV-1:0] pn [T];
    logic [CW-1:0] feat [T];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spatial_encoder_multimod #(
        .HV_DIMENSION  (HV),
        .CHANNEL_WIDTH (CW),
        .NUM_MODALITIES(NM),
        .MOD_CHANNELS  (MODC),
        .TOTAL_CHANNELS(T),
        .ADDR_W        (AW)
    ) dut (
        .Clk_CI           (clk),
        .Reset_RI         (rst),
        .ValidIn_SI       (valid_in),
        .ReadyOut_SO      (ready_out),
        .ChannelsInput_DI (chans),
        .ValidOut_SO      (valid_out),
        .ReadyIn_SI       (ready_in),
        .HypervectorOut_DO(hv_out),
        .MemReqValid_SO   (req_valid),
        .MemReqReady_SI   (req_ready),
        .MemAddr_DO       (mem_addr),
        .MemRespValid_SI  (resp_valid),
        .MemIM_DI         (mem_im),
        .MemProjPos_DI    (mem_pos),
        .MemProjNeg_DI    (mem_neg),
        .Busy_SO          (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [HV-1:0] chan_hv(input int c);
        return im[c] ^ ((feat[c] >= CW'(1 << (CW - 1))) ? pn[c] : pp[c]);
    endfunction

    // Reference: count ones per bit with plain integers, then apply the majority/tie rules.
    function automatic logic [HV-1:0] ref_hv();
        logic [HV-1:0] m [NM];
        logic [HV-1:0] res;
        int base = 0;
        for (int mm = 0; mm < NM; mm++) begin
            for (int k = 0; k < HV; k++) begin
                int ones = 0;
                logic [HV-1:0] tie;
                for (int j = 0; j < NCH[mm]; j++) ones += int'(chan_hv(base + j)[k]);
                tie = (NCH[mm] > 1) ? (chan_hv(base) ^ chan_hv(base + 1)) : chan_hv(base);
                if (2 * ones > NCH[mm]) m[mm][k] = 1'b1;
                else if (2 * ones < NCH[mm]) m[mm][k] = 1'b0;
                else m[mm][k] = tie[k];
            end
            base += NCH[mm];
        end
        for (int k = 0; k < HV; k++) begin
            int ones = 0;
            for (int mm = 0; mm < NM; mm++) ones += int'(m[mm][k]);
            if (2 * ones > NM) res[k] = 1'b1;
            else if (2 * ones < NM) res[k] = 1'b0;
            else res[k] = m[0][k];
        end
        return res;
    endfunction

    function automatic logic [T*CW-1:0] pack_feat();
        logic [T*CW-1:0] p = '0;
        for (int c = 0; c < T; c++) p[(T-1-c)*CW +: CW] = feat[c];
        return p;
    endfunction

    task automatic randomize_sample();
        for (int c = 0; c < T; c++) begin
            feat[c] = CW'($urandom);
            im[c]   = HV'($urandom);
            pp[c]   = HV'($urandom);
            pn[c]   = HV'($urandom);
        end
    endtask

    task automatic drive_row(input int c);
        mem_im  = im[c];
        mem_pos = pp[c];
        mem_neg = pn[c];
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready_out), 32'd1);
        check({tag, "_valid"}, 32'(valid_out), 32'd0);
        check({tag, "_req"}, 32'(req_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_hv"}, 32'(hv_out), 32'd0);
    endtask

    // Runs one sample, acting as the memory; s = request stall cycles, d = response delay,
    // spur = respond spuriously during REQ, hold = cycles downstream is not ready,
    // abort_ch = channel whose WAIT gets a reset (-1 for none).
    task automatic run_sample(input int s, input int d, input bit spur, input int hold,
                              input int abort_ch);
        int cyc = 0, ch = 0, sc = 0, dc = 0;
        bit pend = 0, done = 0;
        logic [HV-1:0] exp = ref_hv();
        @(negedge clk);
        check("ready_idle", 32'(ready_out), 32'd1);
        valid_in = 1'b1;
        chans    = pack_feat();
        while (!done) begin
            @(negedge clk);
            cyc++;
            valid_in   = 1'b0;
            chans      = (T*CW)'({$urandom, $urandom});
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            mem_im     = HV'($urandom);
            mem_pos    = HV'($urandom);
            mem_neg    = HV'($urandom);
            if (cyc > 2000) begin
                check("valid_out_timeout", 32'(valid_out), 32'd1);
                done = 1;
            end else if (pend) begin
                check("req_low_in_wait", 32'(req_valid), 32'd0);
                if (ch == abort_ch) begin
                    rst        = 1'b1;
                    resp_valid = 1'b1;
                    drive_row(ch);
                    @(negedge clk);
                    rst        = 1'b0;
                    resp_valid = 1'b0;
                    check_reset_outputs("abort");
                    done = 1;
                end else if (dc < d) begin
                    dc++;
                end else begin
                    resp_valid = 1'b1;
                    drive_row(ch);
                    pend = 0;
                    ch++;
                end
            end else if (req_valid) begin
                check("req_addr", 32'(mem_addr), 32'(ch));
                if (spur) resp_valid = 1'b1;
                if (sc < s) begin
                    sc++;
                end else begin
                    req_ready = 1'b1;
                    pend = 1;
                    sc = 0;
                    dc = 0;
                end
            end else if (valid_out) begin
                check("latency", 32'(cyc), 32'(BASE_LAT + T * (s + d)));
                check("channels_fetched", 32'(ch), 32'(T));
                check("hv_out", 32'(hv_out), 32'(exp));
                check("ready_in_done", 32'(ready_out), 32'd0);
                valid_in = 1'b1;
                ready_in = (hold == 0);
                for (int i = 0; i < hold; i++) begin
                    @(negedge clk);
                    check("hold_valid", 32'(valid_out), 32'd1);
                    check("hold_hv", 32'(hv_out), 32'(exp));
                    check("hold_ready_out", 32'(ready_out), 32'd0);
                    if (i == hold - 1) ready_in = 1'b1;
                end
                @(negedge clk);
                check("exit_valid", 32'(valid_out), 32'd0);
                check("exit_idle", 32'(busy), 32'd0);
                check("exit_ready_out", 32'(ready_out), 32'd1);
                valid_in = 1'b0;
                ready_in = 1'b0;
                done = 1;
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        valid_in   = 1'b0;
        ready_in   = 1'b0;
        chans      = '0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_im     = '0;
        mem_pos    = '0;
        mem_neg    = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed: zero features pick ProjPos = 0, so IM rows alone form the result.
        randomize_sample();
        for (int c = 0; c < T; c++) begin
            feat[c] = '0;
            pp[c]   = '0;
        end
        im[0] = 16'hFFFF; im[1] = 16'h0000;
        im[2] = 16'h00FF; im[3] = 16'h0F0F; im[4] = 16'h0000;
        im[5] = 16'hFF00; im[6] = 16'hF0F0; im[7] = 16'h0FF0; im[8] = 16'h00FF;
        im[9] = 16'h3333;
        run_sample(0, 0, 1'b0, 0, -1);

        for (int i = 0; i < 4; i++) begin
            randomize_sample();
            run_sample(0, 0, 1'b0, 0, -1);
        end

        randomize_sample();
        run_sample(5, 3, 1'b1, 0, -1);

        randomize_sample();
        run_sample(0, 0, 1'b0, 10, -1);

        randomize_sample();
        run_sample(0, 0, 1'b0, 0, 5);
        randomize_sample();
        run_sample(0, 0, 1'b0, 0, -1);

        for (int i = 0; i < 3; i++) begin
            randomize_sample();
            run_sample(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b1,
                       int'($urandom_range(0, 3)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
